enemy_spawner: RTL and testbench

//  Upstream launcher for the 10-slot enemy Y-coordinate counter bank.

---
 rtl/enemy_spawner.sv | 140 ++++++++++++++
 tb/tb_enemy_spawner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawner.sv
// Purpose: launches enemy planes into the lowest free slot after a pseudo-random gap, retires hit/edge planes.
// Latency: retirement and launch outputs are registered, visible one clk after the causing inputs.
// Backpressure: with every slot busy the launcher holds in LAUNCH (all_busy=1) until a slot frees up.
module enemy_spawner #(
    parameter int unsigned GAP_UNIT  = 32'd12500000,
    parameter int unsigned JIT_UNIT  = 32'd781250,
    parameter int unsigned X_MIN     = 32'd8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       game_en,
    input  logic [1:0] spawn_rate,
    input  logic [9:0] hit,
    input  logic [9:0] touch_edge,
    output logic [9:0] c_en,
    output logic [9:0] des,
    output logic       x_wr_en,
    output logic [3:0] x_wr_slot,
    output logic [7:0] x_wr_val,
    output logic [3:0] escaped_cnt,
    output logic       all_busy
);

    typedef enum logic [1:0] {IDLE, COUNT, LAUNCH} state_t;

    state_t      state;
    logic [9:0]  active;
    logic [15:0] lfsr;
    logic [31:0] gap_cnt;
    logic [31:0] gap;
    logic [9:0]  free_mask;
    logic [9:0]  retire_mask;
    logic [9:0]  escape_mask;
    logic [9:0]  launch_mask;
    logic        any_free;
    logic        do_launch;
    logic [3:0]  free_idx;
    logic [3:0]  esc_add;
    logic [4:0]  esc_sum;

    assign c_en = active;

    // Gap is recomputed every cycle but only captured when the counter reloads.
    assign gap = GAP_UNIT * (32'd4 - {30'd0, spawn_rate})
               + {28'd0, lfsr[11:8]} * JIT_UNIT;

    // A slot still showing its des pulse is not free, so it is never relaunched in that cycle.
    assign free_mask   = ~active & ~des;
    assign any_free    = |free_mask;
    assign retire_mask = active & (hit | touch_edge);
    // Hit takes priority: a plane both hit and at the edge does not count as an escape.
    assign escape_mask = active & touch_edge & ~hit;
    assign do_launch   = (state == LAUNCH) && game_en && any_free;
    assign launch_mask = do_launch ? (10'd1 << free_idx) : 10'd0;
    assign esc_sum     = {1'b0, escaped_cnt} + {1'b0, esc_add};

    // Lowest free slot index and number of escapes this cycle.
    always_comb begin
        free_idx = 4'd0;
        esc_add  = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx = 4'(i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            esc_add = esc_add + {3'd0, escape_mask[i]};
        end
    end

    // Free-running Fibonacci LFSR, taps for x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Retirement pulses and saturating escape counter; these run regardless of game_en.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            des         <= 10'd0;
            escaped_cnt <= 4'd0;
        end else begin
            des         <= retire_mask;
            escaped_cnt <= esc_sum[4] ? 4'hF : esc_sum[3:0];
        end
    end

    // Launch FSM; also owns the active register since launch and retirement both modify it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            active    <= 10'd0;
            gap_cnt   <= 32'd0;
            x_wr_en   <= 1'b0;
            x_wr_slot <= 4'd0;
            x_wr_val  <= 8'd0;
            all_busy  <= 1'b0;
        end else begin
            active   <= (active & ~retire_mask) | launch_mask;
            x_wr_en  <= 1'b0;
            all_busy <= 1'b0;
            if (!game_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        gap_cnt <= gap;
                        state   <= COUNT;
                    end
                    COUNT: begin
                        // The edge that brings the count to zero also enters LAUNCH.
                        if (gap_cnt <= 32'd1) begin
                            gap_cnt <= 32'd0;
                            state   <= LAUNCH;
                        end else begin
                            gap_cnt <= gap_cnt - 32'd1;
                        end
                    end
                    LAUNCH: begin
                        if (any_free) begin
                            x_wr_en   <= 1'b1;
                            x_wr_slot <= free_idx;
                            x_wr_val  <= 8'(X_MIN) + {1'b0, lfsr[6:0]};
                            gap_cnt   <= gap;
                            state     <= COUNT;
                        end else begin
                            all_busy <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawner.sv
// Purpose: randomized and directed stimulus for enemy_spawner against a timestamp-based reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable; the bench drives inputs freely every cycle.
module tb_enemy_spawner;

    localparam int          GAP_U = 16;
    localparam int          JIT_U = 1;
    localparam int          XMIN  = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk;
    logic       reset_n;
    logic       game_en;
    logic [1:0] spawn_rate;
    logic [9:0] hit;
    logic [9:0] touch_edge;
    logic [9:0] c_en;
    logic [9:0] des;
    logic       x_wr_en;
    logic [3:0] x_wr_slot;
    logic [7:0] x_wr_val;
    logic [3:0] escaped_cnt;
    logic       all_busy;

    enemy_spawner #(
        .GAP_UNIT (GAP_U),
        .JIT_UNIT (JIT_U),
        .X_MIN    (XMIN),
        .LFSR_SEED(SEED)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .game_en    (game_en),
        .spawn_rate (spawn_rate),
        .hit        (hit),
        .touch_edge (touch_edge),
        .c_en       (c_en),
        .des        (des),
        .x_wr_en    (x_wr_en),
        .x_wr_slot  (x_wr_slot),
        .x_wr_val   (x_wr_val),
        .escaped_cnt(escaped_cnt),
        .all_busy   (all_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 counting, 2 waiting to launch.
    // Launch time is kept as an absolute cycle number rather than a down-counter.
    logic [9:0]  m_active;
    logic [9:0]  m_des;
    int          m_esc;
    bit          m_busy;
    bit          m_xen;
    int          m_xslot;
    int          m_xval;
    int          m_phase;
    int          m_launch_at;
    int          m_tick;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic model_reset();
        m_active = '0; m_des = '0; m_esc = 0; m_busy = 0; m_xen = 0;
        m_xslot = 0; m_xval = 0; m_phase = 0; m_launch_at = 0;
        m_tick = 0; m_lfsr = SEED;
    endtask

    task automatic model_step();
        int         free_k;
        int         g;
        int         esc_add;
        logic [9:0] nact;
        logic [9:0] ndes;
        if (!reset_n) begin
            model_reset();
            return;
        end
        free_k = -1;
        for (int i = 0; i < 10; i++)
            if (!m_active[i] && !m_des[i] && free_k < 0) free_k = i;
        g = GAP_U * (4 - int'(spawn_rate)) + JIT_U * int'(m_lfsr[11:8]);
        nact = m_active; ndes = '0; esc_add = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_active[i] && (hit[i] || touch_edge[i])) begin
                nact[i] = 1'b0;
                ndes[i] = 1'b1;
                if (!hit[i]) esc_add++;
            end
        end
        m_xen = 0; m_busy = 0;
        if (!game_en) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_launch_at = m_tick + g + 1;
        end else if (m_phase == 1) begin
            if (m_tick + 1 >= m_launch_at) m_phase = 2;
        end else begin
            if (free_k >= 0) begin
                nact[free_k] = 1'b1;
                m_xen = 1; m_xslot = free_k;
                m_xval = XMIN + int'(m_lfsr[6:0]);
                m_phase = 1;
                m_launch_at = m_tick + g + 1;
            end else begin
                m_busy = 1;
            end
        end
        m_esc = (m_esc + esc_add > 15) ? 15 : m_esc + esc_add;
        m_active = nact; m_des = ndes;
        m_lfsr = lfsr_next(m_lfsr);
        m_tick++;
    endtask

    task automatic compare_all();
        check("c_en", 32'(c_en), 32'(m_active));
        check("des", 32'(des), 32'(m_des));
        check("x_wr_en", 32'(x_wr_en), 32'(m_xen));
        check("x_wr_slot", 32'(x_wr_slot), 32'(m_xslot));
        check("x_wr_val", 32'(x_wr_val), 32'(m_xval));
        check("escaped_cnt", 32'(escaped_cnt), 32'(m_esc));
        check("all_busy", 32'(all_busy), 32'(m_busy));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_xen(input string tag, input int bound, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!x_wr_en && n < bound);
        if (!x_wr_en) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int         n;
    int         e0;
    int         s;
    int         first_delay;
    logic [15:0] seed_v;

    initial begin
        seed_v = SEED;
        first_delay = GAP_U * 1 + JIT_U * int'(seed_v[11:8]) + 2;
        reset_n = 1'b0; game_en = 1'b0; spawn_rate = 2'd3; hit = '0; touch_edge = '0;
        model_reset();
        cycle(); cycle();
        check("rst_c_en", 32'(c_en), 32'd0);
        check("rst_escaped", 32'(escaped_cnt), 32'd0);
        check("rst_x_wr_en", 32'(x_wr_en), 32'd0);

        // First launch delay and slot.
        reset_n = 1'b1; game_en = 1'b1;
        wait_xen("first_launch", 200, n);
        check("first_delay", 32'(n), 32'(first_delay));
        check("first_slot", 32'(x_wr_slot), 32'd0);
        check("first_c_en", 32'(c_en), 32'h001);

        // Fill every slot, then confirm the launcher stalls.
        n = 0;
        while (c_en != 10'h3FF && n < 3000) begin cycle(); n++; end
        check("fill_all", 32'(c_en), 32'h3FF);
        n = 0;
        while (!all_busy && n < 100) begin cycle(); n++; end
        check("all_busy_set", 32'(all_busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("busy_no_launch", 32'(x_wr_en), 32'd0);
        end
        hit = 10'h010;
        cycle();
        hit = '0;
        check("hit4_des", 32'(des), 32'h010);
        check("hit4_c_en", 32'(c_en), 32'h3EF);
        wait_xen("relaunch4", 10, n);
        check("relaunch_slot", 32'(x_wr_slot), 32'd4);

        // Simultaneous hit and edge on slot 2: one des pulse, no escape.
        e0 = m_esc;
        hit = 10'h004; touch_edge = 10'h004;
        cycle();
        hit = '0; touch_edge = '0;
        check("both_des", 32'(des), 32'h004);
        check("both_no_escape", 32'(escaped_cnt), 32'(e0));
        cycle();
        check("both_des_once", 32'(des[2]), 32'd0);

        // Sixteen separate escapes saturate the counter.
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (m_active == 10'd0 && n < 200) begin cycle(); n++; end
            s = 0;
            for (int i = 9; i >= 0; i--) if (m_active[i]) s = i;
            touch_edge = 10'd1 << s;
            cycle();
            touch_edge = '0;
            for (int j = 0; j < 5; j++) cycle();
        end
        check("escape_saturate", 32'(escaped_cnt), 32'hF);

        // Drop game_en while stalled in LAUNCH; retirement must still work.
        n = 0;
        while (!all_busy && n < 3000) begin cycle(); n++; end
        check("busy_again", 32'(all_busy), 32'd1);
        game_en = 1'b0; hit = 10'h080;
        cycle();
        hit = '0;
        check("frozen_des", 32'(des), 32'h080);
        check("frozen_busy_clear", 32'(all_busy), 32'd0);
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("frozen_no_launch", 32'(x_wr_en), 32'd0);
        end

        // Randomized run: sparse hits/edges, game_en toggles, rate changes, occasional reset.
        game_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 10; i++) begin
                hit[i]        = ($urandom_range(0, 15) == 0);
                touch_edge[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 99) == 0) game_en = ~game_en;
            if ($urandom_range(0, 199) == 0) spawn_rate = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 999) != 0);
            cycle();
        end
        hit = '0; touch_edge = '0; reset_n = 1'b1;

        // Reset in the middle of COUNT: LFSR restarts, so the first delay repeats.
        reset_n = 1'b0; cycle();
        reset_n = 1'b1; game_en = 1'b1; spawn_rate = 2'd3;
        wait_xen("pre_reset_launch", 200, n);
        for (int i = 0; i < 5; i++) cycle();
        reset_n = 1'b0;
        cycle();
        check("midrst_c_en", 32'(c_en), 32'd0);
        check("midrst_escaped", 32'(escaped_cnt), 32'd0);
        reset_n = 1'b1;
        wait_xen("post_reset_launch", 200, n);
        check("restart_delay", 32'(n), 32'(first_delay));
        check("restart_slot", 32'(x_wr_slot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
